nn_zoom_out: RTL and testbench

Streaming image down-scaler; the reverse direction of the nearest-neighbour zoom-in block. Accepts a `largura` x `altura` 8-bit grey-scale frame in raster order over a valid/ready handshake. Emits a (`largura`/`zoom`) x (`altura`/`zoom`) frame, also raster order, one output pixel per `zoom` x `zoom` input block. Sits in the image pipeline between the pixel source (frame memory reader) and the output/display writer.

---
 rtl/zoom_pkg.sv | 20 ++
 rtl/zoom_out_linebuf.sv | 27 ++
 rtl/nn_zoom_out.sv | 137 +++++++++++++
 tb/tb_nn_zoom_out.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// Shared types and sizing helpers for the zoom-in / zoom-out pixel blocks.
// Accumulator width helper is common to both directions.
package zoom_pkg;

    typedef logic [7:0] pixel_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width needed to sum zoom*zoom 8-bit pixels.
    function automatic int acc_w(input int z);
        return 8 + 2 * clog2(z);
    endfunction

endpackage

// File: rtl/zoom_out_linebuf.sv
// One entry per output column: synchronous write, combinational read.
// Data width is a parameter so it holds pixels or block accumulators.
module zoom_out_linebuf
    import zoom_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Column entry update; contents are never cleared.
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nn_zoom_out.sv
// Streaming down-scaler: one output pixel per zoom x zoom input block.
// Define ZOOM_OUT_AVG_EN for block averaging instead of top-left pick.
module nn_zoom_out
    import zoom_pkg::*;
#(
    parameter int largura = 4,
    parameter int altura  = 4,
    parameter int zoom    = 2
) (
    input  logic   clock,
    input  logic   reset,
    input  pixel_t in_pixel,
    input  logic   in_valid,
    output logic   in_ready,
    output pixel_t out_pixel,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   frame_done
);

    localparam int NLARG = largura / zoom;
    localparam int NALT  = altura / zoom;
    localparam int CW    = (clog2(NLARG) > 0) ? clog2(NLARG) : 1;
    localparam int LW    = (clog2(NALT) > 0) ? clog2(NALT) : 1;
    localparam int ZW    = (clog2(zoom) > 0) ? clog2(zoom) : 1;
    localparam int SH    = 2 * clog2(zoom);
`ifdef ZOOM_OUT_AVG_EN
    localparam int DW    = acc_w(zoom);
`else
    localparam int DW    = 8;
`endif

    localparam logic [CW-1:0] CMAX = CW'(NLARG - 1);
    localparam logic [LW-1:0] LMAX = LW'(NALT - 1);
    localparam logic [ZW-1:0] ZMAX = ZW'(zoom - 1);

    logic [CW-1:0] r_coluna;
    logic [ZW-1:0] r_ncoluna;
    logic [LW-1:0] r_linha;
    logic [ZW-1:0] r_nlinha;
    pixel_t        r_out_pixel;
    logic          r_out_valid;
    logic          r_out_last;

    logic          w_in_xfer;
    logic          w_out_xfer;
    logic          w_first;
    logic          w_ncol_end;
    logic          w_col_end;
    logic          w_nlin_end;
    logic          w_lin_end;
    logic          w_complete;
    logic          w_we;
    logic [DW-1:0] w_rd;
    logic [DW-1:0] w_sum;
    pixel_t        w_result;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_ncol_end = (r_ncoluna == ZMAX);
    assign w_col_end  = (r_coluna == CMAX);
    assign w_nlin_end = (r_nlinha == ZMAX);
    assign w_lin_end  = (r_linha == LMAX);
    assign w_first    = (r_ncoluna == '0) && (r_nlinha == '0);
    assign w_complete = w_in_xfer && w_ncol_end && w_nlin_end;

`ifdef ZOOM_OUT_AVG_EN
    assign w_we     = w_in_xfer;
    assign w_sum    = w_first ? DW'(in_pixel) : w_rd + DW'(in_pixel);
    assign w_result = 8'(w_sum >> SH);
`else
    assign w_we     = w_in_xfer && w_first;
    assign w_sum    = w_first ? in_pixel : w_rd;
    assign w_result = w_sum;
`endif

    zoom_out_linebuf #(
        .DEPTH (NLARG),
        .AW    (CW),
        .DW    (DW)
    ) u_linebuf (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_coluna),
        .i_wdata (w_sum),
        .i_raddr (r_coluna),
        .o_rdata (w_rd)
    );

    // Raster position: ncoluna fastest, then coluna, nlinha, linha.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_coluna  <= '0;
            r_ncoluna <= '0;
            r_linha   <= '0;
            r_nlinha  <= '0;
        end else if (w_in_xfer) begin
            if (!w_ncol_end) begin
                r_ncoluna <= r_ncoluna + 1'b1;
            end else begin
                r_ncoluna <= '0;
                if (!w_col_end) begin
                    r_coluna <= r_coluna + 1'b1;
                end else begin
                    r_coluna <= '0;
                    if (!w_nlin_end) begin
                        r_nlinha <= r_nlinha + 1'b1;
                    end else begin
                        r_nlinha <= '0;
                        r_linha  <= w_lin_end ? '0 : r_linha + 1'b1;
                    end
                end
            end
        end
    end

    // Output register: reload on block completion, else clear on take.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_pixel <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_complete) begin
            r_out_pixel <= w_result;
            r_out_valid <= 1'b1;
            r_out_last  <= w_col_end && w_lin_end;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready   = !(r_out_valid && !out_ready);
    assign out_pixel  = r_out_pixel;
    assign out_valid  = r_out_valid;
    assign frame_done = w_out_xfer && r_out_last;

endmodule

// File: tb/tb_nn_zoom_out.sv
// Scoreboard bench for nn_zoom_out: 4x4 zoom=2 and 4x4 zoom=1 instances.
// Expected pixels come from a block model (NN or AVG per ZOOM_OUT_AVG_EN).
module tb_nn_zoom_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv = 1'b0;
    logic [7:0] ipx = '0;
    logic       ordy = 1'b1;
    int         sel = 0;
    int         cyc = 0;

    logic       ir0, ov0, fd0, ir1, ov1, fd1;
    logic [7:0] opx0, opx1;
    logic       ir_s, ov_s, fd_s;
    logic [7:0] opx_s;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pixq[$];
    logic [7:0] expq[$];
    int         cidxq[$];
    bit         efdq[$];
    int         acc_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nn_zoom_out #(.largura(4), .altura(4), .zoom(2)) u_z2 (
        .clock      (clk),
        .reset      (rst),
        .in_pixel   (ipx),
        .in_valid   (iv && sel == 0),
        .in_ready   (ir0),
        .out_pixel  (opx0),
        .out_valid  (ov0),
        .out_ready  (sel == 0 ? ordy : 1'b1),
        .frame_done (fd0)
    );

    nn_zoom_out #(.largura(4), .altura(4), .zoom(1)) u_z1 (
        .clock      (clk),
        .reset      (rst),
        .in_pixel   (ipx),
        .in_valid   (iv && sel == 1),
        .in_ready   (ir1),
        .out_pixel  (opx1),
        .out_valid  (ov1),
        .out_ready  (sel == 1 ? ordy : 1'b1),
        .frame_done (fd1)
    );

    assign ir_s  = (sel == 0) ? ir0 : ir1;
    assign ov_s  = (sel == 0) ? ov0 : ov1;
    assign fd_s  = (sel == 0) ? fd0 : fd1;
    assign opx_s = (sel == 0) ? opx0 : opx1;

    task automatic clear_sb();
        pixq.delete();
        expq.delete();
        cidxq.delete();
        efdq.delete();
        acc_cyc.delete();
    endtask

    // Append a 4x4 frame and its expected blocks to the scoreboard.
    task automatic push_frame(input logic [7:0] f[16], input int z);
        int base, nb, sum;
        base = pixq.size();
        nb = 4 / z;
        for (int i = 0; i < 16; i++) pixq.push_back(f[i]);
        for (int br = 0; br < nb; br++) begin
            for (int bc = 0; bc < nb; bc++) begin
                sum = 0;
                for (int r = 0; r < z; r++)
                    for (int c = 0; c < z; c++)
                        sum += f[(br * z + r) * 4 + bc * z + c];
`ifdef ZOOM_OUT_AVG_EN
                expq.push_back(8'(sum / (z * z)));
`else
                expq.push_back(f[(br * z) * 4 + bc * z]);
`endif
                cidxq.push_back(base + (br * z + z - 1) * 4 + bc * z + z - 1);
                efdq.push_back(br == nb - 1 && bc == nb - 1);
            end
        end
    endtask

    task automatic drive_all();
        int t;
        for (int i = 0; i < pixq.size(); i++) begin
            @(posedge clk); #1;
            iv = 1'b1;
            ipx = pixq[i];
            t = 0;
            forever begin
                @(negedge clk);
                if (ir_s) break;
                t++;
                if (t > 200) break;
                @(posedge clk); #1;
            end
            if (t > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL drive_timeout: input %0d not accepted, in_ready=%0b required 1", i, ir_s);
                break;
            end
            acc_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic collect(input int nexp, input bit stall,
                           input bit chk_lat, input int exp_fd);
        int got, fdn, t, stalled, idx;
        bit held_v;
        logic [7:0] held, e;
        bit efd;
        got = 0; fdn = 0; t = 0; stalled = 0; held_v = 0; held = '0;
        ordy = !stall;
        while (got < nexp && t < 300) begin
            @(negedge clk);
            t++;
            if (fd_s) fdn++;
            if (ov_s && ordy) begin
                e = expq.pop_front();
                idx = cidxq.pop_front();
                efd = efdq.pop_front();
                n_cmp++;
                if (opx_s !== e) begin
                    n_bad++;
                    $display("FAIL out_pixel[%0d]: got %0d required %0d", got, opx_s, e);
                end
                n_cmp++;
                if (fd_s !== efd) begin
                    n_bad++;
                    $display("FAIL frame_done[%0d]: got %0b required %0b", got, fd_s, efd);
                end
                if (chk_lat) begin
                    n_cmp++;
                    if (idx >= acc_cyc.size() || acc_cyc[idx] !== cyc - 1) begin
                        n_bad++;
                        $display("FAIL latency[%0d]: valid at cycle %0d, input %0d not accepted one cycle before",
                                 got, cyc, idx);
                    end
                end
                got++;
            end else if (ov_s && !ordy) begin
                if (held_v) begin
                    n_cmp++;
                    if (opx_s !== held) begin
                        n_bad++;
                        $display("FAIL stall_hold: got %0d required %0d", opx_s, held);
                    end
                end
                held = opx_s;
                held_v = 1'b1;
                n_cmp++;
                if (ir_s !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_in_ready: got %0b required 0", ir_s);
                end
                stalled++;
            end
            @(posedge clk); #1;
            if (stall && stalled >= 5) ordy = 1'b1;
        end
        ordy = 1'b1;
        n_cmp++;
        if (got != nexp) begin
            n_bad++;
            $display("FAIL collect_timeout: got %0d outputs required %0d", got, nexp);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (fd_s) fdn++;
            n_cmp++;
            if (ov_s !== 1'b0) begin
                n_bad++;
                $display("FAIL extra_output: out_valid=%0b required 0", ov_s);
            end
        end
        n_cmp++;
        if (fdn != exp_fd) begin
            n_bad++;
            $display("FAIL frame_done_count: got %0d required %0d", fdn, exp_fd);
        end
    endtask

    task automatic run(input int nexp, input bit stall,
                       input bit chk_lat, input int exp_fd);
        fork
            drive_all();
            collect(nexp, stall, chk_lat, exp_fd);
        join
    endtask

    function automatic void ramp(output logic [7:0] f[16]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[r * 4 + c] = 8'(16 * r + c);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp += 4;
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %0b%0b required 00", ov0, ov1);
        end
        if (opx0 !== 8'd0 || opx1 !== 8'd0) begin
            n_bad++; $display("FAIL reset_out_pixel: got %0d/%0d required 0", opx0, opx1);
        end
        if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %0b%0b required 11", ir0, ir1);
        end
        if (fd0 !== 1'b0 || fd1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_frame_done: got %0b%0b required 00", fd0, fd1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_frame();
        logic [7:0] f[16];
        sel = 0;
        clear_sb();
        ramp(f);
        push_frame(f, 2);
        run(4, 1'b0, 1'b1, 1);
    endtask

    task automatic test_stall();
        logic [7:0] f[16];
        sel = 0;
        clear_sb();
        ramp(f);
        push_frame(f, 2);
        run(4, 1'b1, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] f[16], g[16];
        sel = 0;
        clear_sb();
        ramp(f);
        for (int i = 0; i < 16; i++) g[i] = 8'd255;
        push_frame(f, 2);
        push_frame(g, 2);
        run(8, 1'b0, 1'b1, 2);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] f[16];
        sel = 0;
        clear_sb();
        ramp(f);
        for (int i = 0; i < 6; i++) pixq.push_back(f[i] + 8'd100);
        ordy = 1'b0;
        drive_all();
        @(negedge clk);
        n_cmp++;
        if (ov0 !== 1'b1) begin
            n_bad++; $display("FAIL midframe_pending: out_valid=%0b required 1", ov0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (ov0 !== 1'b0) begin
            n_bad++; $display("FAIL midframe_drop: out_valid=%0b required 0", ov0);
        end
        if (ir0 !== 1'b1) begin
            n_bad++; $display("FAIL midframe_in_ready: got %0b required 1", ir0);
        end
        clear_sb();
        push_frame(f, 2);
        run(4, 1'b0, 1'b1, 1);
    endtask

    task automatic test_zoom1();
        logic [7:0] f[16];
        sel = 1;
        clear_sb();
        for (int i = 0; i < 16; i++) f[i] = 8'($urandom_range(0, 255));
        push_frame(f, 1);
        run(16, 1'b0, 1'b1, 1);
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_reset_midframe();
        test_zoom1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
